i2c_target: RTL and testbench

Bus-side responder for the team's I2C wrapper: the target end of the link driven by the existing I2C master. Oversamples the open-drain `scl`/`sda` lines with the system clock, detects START/STOP, matches an ADDRWIDTH-bit address plus R/W bit, and ACKs by pulling `sda` low through `sda_en`. Delivers one written byte to the user side, or serialises one user-supplied byte back to the master, per addressed transfer.

---
 rtl/i2c_pkg.sv | 18 +
 rtl/i2c_line_sync.sv | 30 +++
 rtl/i2c_target.sv | 165 ++++++++++++++++
 tb/tb_i2c_target.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/i2c_pkg.sv
// Shared types and encodings for the I2C target.
package i2c_pkg;

    typedef enum logic [2:0] {
        IDLE,
        ADDR,
        ADDR_ACK,
        WR_DATA,
        WR_ACK,
        RD_DATA,
        RD_ACK,
        WAIT_STOP
    } i2c_tgt_state_t;

    localparam logic I2C_WRITE = 1'b0;
    localparam logic I2C_READ  = 1'b1;

endpackage

// File: rtl/i2c_line_sync.sv
// Two-flop synchroniser for one raw bus line, plus rise/fall detection on the synchronised level.
module i2c_line_sync (
    input  logic clk,
    input  logic reset,
    input  logic din,
    output logic q,
    output logic rise_c,
    output logic fall_c
);

    logic meta;
    logic prev;

    // Sync chain; resets to the idle-high bus level so reset itself produces no edge
    always_ff @(posedge clk) begin
        if (reset) begin
            meta <= 1'b1;
            q    <= 1'b1;
            prev <= 1'b1;
        end else begin
            meta <= din;
            q    <= meta;
            prev <= q;
        end
    end

    assign rise_c = q & ~prev;
    assign fall_c = ~q & prev;

endmodule

// File: rtl/i2c_target.sv
// I2C target: address match, single-byte write capture or single-byte read return.
module i2c_target #(
    parameter int unsigned           DATAWIDTH = 8,
    parameter int unsigned           ADDRWIDTH = 6,
    parameter logic [ADDRWIDTH-1:0]  OWN_ADDR  = 6'b00_1101
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 scl,
    input  logic                 sda_in,
    output logic                 sda_en,
    input  logic [DATAWIDTH-1:0] tx_data,
    output logic                 rd_req,
    output logic [DATAWIDTH-1:0] rx_data,
    output logic                 rx_valid,
    output logic                 busy
);
    import i2c_pkg::*;

    localparam int unsigned CW = $clog2(ADDRWIDTH + 2);
    localparam int unsigned SW = (DATAWIDTH > ADDRWIDTH + 1) ? DATAWIDTH : ADDRWIDTH + 1;

    i2c_tgt_state_t state;
    logic [SW-1:0]  shift;
    logic [CW-1:0]  cnt;
    logic           last;
    logic           rw_bit;

    logic scl_q, scl_rise, scl_fall;
    logic sda_q, sda_rise, sda_fall;
    logic start_c, stop_c;

    i2c_line_sync u_scl_sync (
        .clk    (clk),
        .reset  (reset),
        .din    (scl),
        .q      (scl_q),
        .rise_c (scl_rise),
        .fall_c (scl_fall)
    );

    i2c_line_sync u_sda_sync (
        .clk    (clk),
        .reset  (reset),
        .din    (sda_in),
        .q      (sda_q),
        .rise_c (sda_rise),
        .fall_c (sda_fall)
    );

    assign start_c = sda_fall & scl_q;
    assign stop_c  = sda_rise & scl_q;

    // Bus FSM; START/STOP override any scl edge seen in the same cycle
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            sda_en   <= 1'b0;
            rd_req   <= 1'b0;
            rx_valid <= 1'b0;
            busy     <= 1'b0;
            rx_data  <= '0;
            shift    <= '0;
            cnt      <= '0;
            last     <= 1'b0;
            rw_bit   <= I2C_WRITE;
        end else begin
            rd_req   <= 1'b0;
            rx_valid <= 1'b0;
            if (start_c) begin
                state  <= ADDR;
                sda_en <= 1'b0;
                busy   <= 1'b0;
                shift  <= '0;
                cnt    <= '0;
                last   <= 1'b0;
            end else if (stop_c) begin
                state  <= IDLE;
                sda_en <= 1'b0;
                busy   <= 1'b0;
                cnt    <= '0;
                last   <= 1'b0;
            end else begin
                case (state)
                    IDLE: ;
                    ADDR: begin
                        if (scl_rise) begin
                            shift <= {shift[SW-2:0], sda_q};
                            if (cnt == CW'(ADDRWIDTH)) last <= 1'b1;
                            else                       cnt  <= cnt + CW'(1);
                        end else if (scl_fall && last) begin
                            cnt  <= '0;
                            last <= 1'b0;
                            if (shift[ADDRWIDTH:1] == OWN_ADDR) begin
                                state  <= ADDR_ACK;
                                sda_en <= 1'b1;
                                busy   <= 1'b1;
                                rw_bit <= shift[0];
                                if (shift[0] == I2C_READ) begin
                                    rd_req <= 1'b1;
                                    shift  <= SW'(tx_data);
                                end
                            end else begin
                                state <= WAIT_STOP;
                            end
                        end
                    end
                    ADDR_ACK: begin
                        if (scl_fall) begin
                            if (rw_bit == I2C_READ) begin
                                state  <= RD_DATA;
                                sda_en <= ~shift[DATAWIDTH-1];
                            end else begin
                                state  <= WR_DATA;
                                sda_en <= 1'b0;
                            end
                        end
                    end
                    WR_DATA: begin
                        if (scl_rise) begin
                            shift <= {shift[SW-2:0], sda_q};
                            if (cnt == CW'(DATAWIDTH - 1)) last <= 1'b1;
                            else                           cnt  <= cnt + CW'(1);
                        end else if (scl_fall && last) begin
                            rx_data  <= shift[DATAWIDTH-1:0];
                            rx_valid <= 1'b1;
                            sda_en   <= 1'b1;
                            state    <= WR_ACK;
                            cnt      <= '0;
                            last     <= 1'b0;
                        end
                    end
                    WR_ACK: begin
                        if (scl_fall) begin
                            sda_en <= 1'b0;
                            state  <= WAIT_STOP;
                        end
                    end
                    RD_DATA: begin
                        if (scl_rise) begin
                            if (cnt == CW'(DATAWIDTH - 1)) last <= 1'b1;
                            else                           cnt  <= cnt + CW'(1);
                        end else if (scl_fall) begin
                            if (last) begin
                                sda_en <= 1'b0;
                                state  <= RD_ACK;
                                cnt    <= '0;
                                last   <= 1'b0;
                            end else begin
                                shift  <= {shift[SW-2:0], 1'b0};
                                sda_en <= ~shift[DATAWIDTH-2];
                            end
                        end
                    end
                    RD_ACK: begin
                        if (scl_rise) state <= WAIT_STOP;
                    end
                    WAIT_STOP: ;
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_i2c_target.sv
// Directed bench for i2c_target: table of single-byte transfers plus hand-written corner sequences.
module tb_i2c_target;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       scl = 1'b1;
    logic       sda_m = 1'b1;
    logic [7:0] tx_data = 8'h00;
    logic       sda_en, rd_req, rx_valid, busy;
    logic [7:0] rx_data;
    logic       sda_bus;

    assign sda_bus = sda_m & ~sda_en;

    always #5 clk = ~clk;

    i2c_target dut (
        .clk      (clk),
        .reset    (reset),
        .scl      (scl),
        .sda_in   (sda_bus),
        .sda_en   (sda_en),
        .tx_data  (tx_data),
        .rd_req   (rd_req),
        .rx_data  (rx_data),
        .rx_valid (rx_valid),
        .busy     (busy)
    );

    int tests = 0;
    int fails = 0;
    int rx_tot = 0;
    int rd_tot = 0;
    int en_tot = 0;

    // Running totals of pulse and drive cycles; transfers diff them
    always @(posedge clk) begin
        if (rx_valid) rx_tot++;
        if (rd_req)   rd_tot++;
        if (sda_en)   en_tot++;
    end

    typedef struct {
        logic [5:0] addr;
        logic       rw;
        logic [7:0] data;
        logic       match;
        logic [7:0] exp_rx;
    } vec_t;

    vec_t vecs [7];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic clks(input int n);
        repeat (n) @(negedge clk);
    endtask

    // START (or repeated START): leaves scl low, mid low phase
    task automatic bus_start();
        sda_m = 1'b1; clks(4);
        scl = 1'b1;   clks(8);
        sda_m = 1'b0; clks(8);
        scl = 1'b0;   clks(4);
    endtask

    task automatic bus_stop();
        sda_m = 1'b0; clks(4);
        scl = 1'b1;   clks(8);
        sda_m = 1'b1; clks(8);
    endtask

    // One clock: drive b, sample bus level and sda_en mid high phase
    task automatic bus_bit(input logic b, output logic s, output logic e);
        sda_m = b; clks(4);
        scl = 1'b1; clks(4);
        s = sda_bus;
        e = sda_en;
        clks(4);
        scl = 1'b0; clks(4);
    endtask

    task automatic send_addr(input logic [5:0] a, input logic rw, output logic ack);
        logic [6:0] b;
        logic s, e;
        b = {a, rw};
        for (int i = 6; i >= 0; i--) bus_bit(b[i], s, e);
        bus_bit(1'b1, s, e);
        ack = ~s;
    endtask

    task automatic send_byte(input logic [7:0] d, output logic ack);
        logic s, e;
        for (int i = 7; i >= 0; i--) bus_bit(d[i], s, e);
        bus_bit(1'b1, s, e);
        ack = ~s;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic       ack, s, e;
        logic [7:0] rd;
        int         rx0, rd0, en0;

        vecs[0] = '{6'h0D, 1'b0, 8'hE5, 1'b1, 8'hE5};
        vecs[1] = '{6'h13, 1'b0, 8'h5A, 1'b0, 8'hE5};
        vecs[2] = '{6'h0D, 1'b1, 8'hA5, 1'b1, 8'hE5};
        vecs[3] = '{6'h0C, 1'b0, 8'h77, 1'b0, 8'hE5};
        vecs[4] = '{6'h2D, 1'b1, 8'h3F, 1'b0, 8'hE5};
        vecs[5] = '{6'h0D, 1'b1, 8'h01, 1'b1, 8'hE5};
        vecs[6] = '{6'h0D, 1'b0, 8'h00, 1'b1, 8'h00};

        reset = 1'b1;
        clks(4);
        chk("rst_sda_en", sda_en, 0);
        chk("rst_busy", busy, 0);
        chk("rst_rx_data", rx_data, 0);
        chk("rst_rx_valid", rx_valid, 0);
        chk("rst_rd_req", rd_req, 0);
        reset = 1'b0;
        clks(4);

        foreach (vecs[k]) begin
            rx0 = rx_tot; rd0 = rd_tot; en0 = en_tot;
            tx_data = vecs[k].data;
            bus_start();
            send_addr(vecs[k].addr, vecs[k].rw, ack);
            chk($sformatf("v%0d_addr_ack", k), ack, vecs[k].match);
            if (vecs[k].rw) begin
                tx_data = ~vecs[k].data;
                for (int i = 7; i >= 0; i--) begin
                    bus_bit(1'b1, s, e);
                    rd[i] = s;
                end
                chk($sformatf("v%0d_rd_data", k), rd, vecs[k].match ? vecs[k].data : 8'hFF);
                bus_bit(1'b1, s, e);
                chk($sformatf("v%0d_nack_release", k), e, 0);
            end else begin
                send_byte(vecs[k].data, ack);
                chk($sformatf("v%0d_wr_ack", k), ack, vecs[k].match);
            end
            chk($sformatf("v%0d_busy", k), busy, vecs[k].match);
            bus_stop();
            chk($sformatf("v%0d_busy_stop", k), busy, 0);
            chk($sformatf("v%0d_rx_data", k), rx_data, vecs[k].exp_rx);
            chk($sformatf("v%0d_rx_pulses", k), rx_tot - rx0, vecs[k].match & ~vecs[k].rw);
            chk($sformatf("v%0d_rd_pulses", k), rd_tot - rd0, vecs[k].match & vecs[k].rw);
            if (!vecs[k].match) chk($sformatf("v%0d_no_drive", k), en_tot - en0, 0);
            clks(8);
        end

        // Repeated START after address ACK abandons the first transfer
        rx0 = rx_tot;
        bus_start();
        send_addr(6'h0D, 1'b0, ack);
        chk("rs_first_ack", ack, 1);
        chk("rs_busy_before", busy, 1);
        bus_start();
        chk("rs_busy_cleared", busy, 0);
        send_addr(6'h0D, 1'b0, ack);
        chk("rs_second_ack", ack, 1);
        send_byte(8'h3C, ack);
        chk("rs_wr_ack", ack, 1);
        bus_stop();
        chk("rs_rx_data", rx_data, 8'h3C);
        chk("rs_rx_pulses", rx_tot - rx0, 1);
        clks(8);

        // STOP after 4 data bits discards the partial byte
        rx0 = rx_tot;
        bus_start();
        send_addr(6'h0D, 1'b0, ack);
        chk("ps_addr_ack", ack, 1);
        bus_bit(1'b1, s, e);
        bus_bit(1'b0, s, e);
        bus_bit(1'b1, s, e);
        bus_bit(1'b0, s, e);
        bus_stop();
        chk("ps_rx_pulses", rx_tot - rx0, 0);
        chk("ps_rx_data", rx_data, 8'h3C);
        chk("ps_sda_en", sda_en, 0);
        chk("ps_busy", busy, 0);
        clks(8);

        // Reset while driving a read 0 bit, then a normal write
        tx_data = 8'hA5;
        bus_start();
        send_addr(6'h0D, 1'b1, ack);
        chk("rr_addr_ack", ack, 1);
        bus_bit(1'b1, s, e);
        chk("rr_bit7", s, 1);
        chk("rr_bit6_drive", sda_en, 1);
        reset = 1'b1;
        @(posedge clk);
        #1;
        chk("rr_release", sda_en, 0);
        clks(2);
        reset = 1'b0;
        sda_m = 1'b1; clks(4);
        scl = 1'b1;   clks(8);
        chk("rr_busy", busy, 0);
        rx0 = rx_tot;
        bus_start();
        send_addr(6'h0D, 1'b0, ack);
        chk("rr_wr_addr_ack", ack, 1);
        send_byte(8'h81, ack);
        chk("rr_wr_ack", ack, 1);
        bus_stop();
        chk("rr_rx_data", rx_data, 8'h81);
        chk("rr_rx_pulses", rx_tot - rx0, 1);
        clks(8);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
